// File: rtl/dpi_init_sequencer.sv
// Holds the DUT in reset, replays init-time DPI calls over a host mailbox and scans non-void returns in MSB first.
// Zero-wait latency: 3 cycles per void call, RET_W+3 per non-void call; stalls on call_ready_i / ret_valid_i.
module dpi_init_sequencer #(
  parameter int                   NUM_CALLS      = 2,
  parameter int                   ARG_W          = 32,
  parameter int                   RET_W          = 32,
  parameter logic [NUM_CALLS-1:0] VOID_MASK      = 2'b01,
  parameter int                   TIMEOUT_CYCLES = 1024,
  parameter int                   IDW            = (NUM_CALLS > 1) ? $clog2(NUM_CALLS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [NUM_CALLS*ARG_W-1:0] call_args_i,
  output logic                       call_valid_o,
  input  logic                       call_ready_i,
  output logic [IDW-1:0]             call_id_o,
  output logic [ARG_W-1:0]           call_arg_o,
  input  logic                       ret_valid_i,
  input  logic [RET_W-1:0]           ret_data_i,
  output logic                       ret_ready_o,
  output logic                       scan_en_o,
  output logic                       scan_data_o,
  output logic                       dut_rst_no,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int SCW = (RET_W > 1) ? $clog2(RET_W) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [SCW-1:0] SC_LAST  = SCW'(RET_W - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_CALLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RET,
    SHIFT,
    ADVANCE,
    DONE,
    ERROR
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   idx_q;
  logic [RET_W-1:0] shift_q;
  logic [SCW-1:0]   shift_cnt_q;
  logic [TW-1:0]    tmo_cnt_q;
  logic             call_valid_q;
  logic             ret_ready_q;
  logic             scan_en_q;
  logic             dut_rst_nq;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic [ARG_W-1:0] arg_sel;
  logic             cur_void;

  always_comb begin
    arg_sel  = '0;
    cur_void = 1'b0;
    for (int i = 0; i < NUM_CALLS; i++) begin
      if (idx_q == IDW'(i)) begin
        arg_sel  = call_args_i[i*ARG_W +: ARG_W];
        cur_void = VOID_MASK[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      shift_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      call_valid_q <= 1'b0;
      ret_ready_q  <= 1'b0;
      scan_en_q    <= 1'b0;
      dut_rst_nq   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state_q      <= ISSUE;
            idx_q        <= '0;
            call_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            dut_rst_nq   <= 1'b0;
          end
        end

        ISSUE: begin
          if (call_ready_i) begin
            state_q      <= WAIT_RET;
            call_valid_q <= 1'b0;
            ret_ready_q  <= 1'b1;
            tmo_cnt_q    <= '0;
          end
        end

        // A return in the expiry cycle is still accepted: handshake has priority.
        WAIT_RET: begin
          if (ret_valid_i) begin
            ret_ready_q <= 1'b0;
            if (cur_void) begin
              state_q <= ADVANCE;
            end else begin
              state_q     <= SHIFT;
              shift_q     <= ret_data_i;
              shift_cnt_q <= '0;
              scan_en_q   <= 1'b1;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TO_LAST)) begin
            state_q     <= ERROR;
            ret_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        SHIFT: begin
          shift_q <= shift_q << 1;
          if (shift_cnt_q == SC_LAST) begin
            state_q   <= ADVANCE;
            scan_en_q <= 1'b0;
          end else begin
            shift_cnt_q <= shift_cnt_q + 1'b1;
          end
        end

        ADVANCE: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            dut_rst_nq <= 1'b1;
          end else begin
            state_q      <= ISSUE;
            idx_q        <= idx_q + 1'b1;
            call_valid_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign call_valid_o = call_valid_q;
  assign call_id_o    = idx_q;
  assign call_arg_o   = call_valid_q ? arg_sel : '0;
  assign ret_ready_o  = ret_ready_q;
  assign scan_en_o    = scan_en_q;
  assign scan_data_o  = scan_en_q & shift_q[RET_W-1];
  assign dut_rst_no   = dut_rst_nq;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_dpi_init_sequencer.sv
// Directed bench for dpi_init_sequencer: cycle table for the nominal run plus hand sequences for stalls, timeout and resets.
module tb_dpi_init_sequencer;

  localparam int NUM_CALLS = 2;
  localparam int ARG_W     = 32;
  localparam int RET_W     = 32;
  localparam int IDW       = 1;
  localparam int TMO       = 8;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic                       start_i = 1'b0;
  logic [NUM_CALLS*ARG_W-1:0] call_args_i = {32'd42, 32'd0};
  logic                       call_valid_o;
  logic                       call_ready_i = 1'b1;
  logic [IDW-1:0]             call_id_o;
  logic [ARG_W-1:0]           call_arg_o;
  logic                       ret_valid_i = 1'b1;
  logic [RET_W-1:0]           ret_data_i;
  logic                       ret_ready_o;
  logic                       scan_en_o;
  logic                       scan_data_o;
  logic                       dut_rst_no;
  logic                       busy_o;
  logic                       done_o;
  logic                       error_o;

  logic        data_auto = 1'b1;
  logic [31:0] ret_data_drv = 32'h0;
  int          host_id = 0;

  // The host answers each call from the id it last accepted: call 0 -> 0, call 1 -> DEADBEEF.
  assign ret_data_i = data_auto ? ((host_id == 1) ? 32'hDEAD_BEEF : 32'h0) : ret_data_drv;

  dpi_init_sequencer #(
    .NUM_CALLS     (NUM_CALLS),
    .ARG_W         (ARG_W),
    .RET_W         (RET_W),
    .VOID_MASK     (2'b01),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .call_args_i (call_args_i),
    .call_valid_o(call_valid_o),
    .call_ready_i(call_ready_i),
    .call_id_o   (call_id_o),
    .call_arg_o  (call_arg_o),
    .ret_valid_i (ret_valid_i),
    .ret_data_i  (ret_data_i),
    .ret_ready_o (ret_ready_o),
    .scan_en_o   (scan_en_o),
    .scan_data_o (scan_data_o),
    .dut_rst_no  (dut_rst_no),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  int          scan_cnt = 0;
  int          ret_hs = 0;
  logic [31:0] scan_acc = '0;
  int          hs_ids[$];

  always @(negedge clk_i) begin
    if (scan_en_o) begin
      scan_acc = {scan_acc[30:0], scan_data_o};
      scan_cnt++;
    end
    if (call_valid_o && call_ready_i) begin
      hs_ids.push_back(int'(call_id_o));
      host_id = int'(call_id_o);
    end
    if (ret_valid_i && ret_ready_o) ret_hs++;
  end

  int checks = 0;
  int failures = 0;
  int tcount = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
    tcount++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // {valid, id, arg[31:0], rr, se, sd, rst_n, busy, done, err}
  function automatic logic [40:0] snap();
    return {call_valid_o, call_id_o, call_arg_o, ret_ready_o, scan_en_o, scan_data_o,
            dut_rst_no, busy_o, done_o, error_o};
  endfunction

  // flags = {ret_ready, scan_en, scan_data, dut_rst_n, busy, done, error}
  function automatic logic [40:0] mk(input logic v, input logic id, input logic [31:0] arg,
                                     input logic [6:0] flags);
    return {v, id, arg, flags};
  endfunction

  // id/arg are only meaningful while a request is offered.
  task automatic cmp_vec(input string name, input logic [40:0] exp);
    logic [40:0] act;
    act = snap();
    if (!exp[40]) act[39:7] = '0;
    chk(name, {23'b0, act}, {23'b0, exp});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_o && !error_o && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", {63'b0, done_o}, 64'd1);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic check_run(input string tag, input int hs_base, input int scan_base);
    chk({tag, "_scan_cnt"}, 64'(scan_cnt - scan_base), 64'd32);
    chk({tag, "_scan_word"}, {32'b0, scan_acc}, 64'hDEAD_BEEF);
    chk({tag, "_hs_cnt"}, 64'(hs_ids.size() - hs_base), 64'd2);
    chk({tag, "_hs_id0"}, 64'((hs_ids.size() > hs_base) ? hs_ids[hs_base] : -1), 64'd0);
    chk({tag, "_hs_id1"}, 64'((hs_ids.size() > hs_base + 1) ? hs_ids[hs_base + 1] : -1), 64'd1);
  endtask

  typedef struct {
    int          cyc;
    logic [40:0] exp;
    string       name;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    int   c, t0, hb, sb, rb;

    tbl[0]  = '{0,  mk(1'b1, 1'b0, 32'd0,  7'b000_0100), "issue0"};
    tbl[1]  = '{1,  mk(1'b0, 1'b0, 32'd0,  7'b100_0100), "wait0"};
    tbl[2]  = '{2,  mk(1'b0, 1'b0, 32'd0,  7'b000_0100), "advance0"};
    tbl[3]  = '{3,  mk(1'b1, 1'b1, 32'd42, 7'b000_0100), "issue1"};
    tbl[4]  = '{4,  mk(1'b0, 1'b0, 32'd0,  7'b100_0100), "wait1"};
    tbl[5]  = '{5,  mk(1'b0, 1'b0, 32'd0,  7'b011_0100), "shift_b31"};
    tbl[6]  = '{6,  mk(1'b0, 1'b0, 32'd0,  7'b011_0100), "shift_b30"};
    tbl[7]  = '{7,  mk(1'b0, 1'b0, 32'd0,  7'b010_0100), "shift_b29"};
    tbl[8]  = '{20, mk(1'b0, 1'b0, 32'd0,  7'b011_0100), "shift_b16"};
    tbl[9]  = '{22, mk(1'b0, 1'b0, 32'd0,  7'b010_0100), "shift_b14"};
    tbl[10] = '{36, mk(1'b0, 1'b0, 32'd0,  7'b011_0100), "shift_b0"};
    tbl[11] = '{37, mk(1'b0, 1'b0, 32'd0,  7'b000_0100), "advance1"};
    tbl[12] = '{38, mk(1'b0, 1'b0, 32'd0,  7'b000_1010), "done_entry"};
    tbl[13] = '{41, mk(1'b0, 1'b0, 32'd0,  7'b000_1010), "done_held"};

    // Reset and idle
    tick(); tick(); tick();
    chk("reset_outputs", {23'b0, snap()}, 64'd0);
    rst_ni = 1'b1;
    tick();
    chk("idle_outputs", {23'b0, snap()}, 64'd0);

    // Nominal run, ready/valid held high
    hb = hs_ids.size(); sb = scan_cnt; rb = ret_hs;
    do_start();
    c = 0;
    for (int i = 0; i < 14; i++) begin
      while (c < tbl[i].cyc) begin
        tick();
        c++;
      end
      cmp_vec(tbl[i].name, tbl[i].exp);
    end
    check_run("nominal", hb, sb);
    chk("nominal_ret_hs", 64'(ret_hs - rb), 64'd2);

    // call_ready_i low for 5 ISSUE cycles of call 1
    hb = hs_ids.size(); sb = scan_cnt;
    do_start();
    tick(); tick();
    call_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ready_stall_hold", {30'b0, call_valid_o, call_id_o, call_arg_o}, {30'b0, 1'b1, 1'b1, 32'd42});
    end
    chk("ready_stall_hs", 64'(hs_ids.size() - hb), 64'd1);
    call_ready_i = 1'b1;
    wait_done(100);
    check_run("stall", hb, sb);

    // Return pulse during ISSUE ignored; real return delayed 3 cycles
    hb = hs_ids.size(); sb = scan_cnt; rb = ret_hs;
    data_auto = 1'b0; ret_data_drv = 32'h0;
    do_start();
    tick(); tick();
    call_ready_i = 1'b0; ret_valid_i = 1'b0;
    tick();
    ret_valid_i = 1'b1; ret_data_drv = 32'h1234_5678;
    tick();
    chk("issue_ret_ignored", {62'b0, call_valid_o, ret_ready_o}, 64'b10);
    chk("issue_ret_hs", 64'(ret_hs - rb), 64'd1);
    ret_valid_i = 1'b0; call_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("delayed_ret_wait", {62'b0, ret_ready_o, scan_en_o}, 64'b10);
      tick();
    end
    ret_valid_i = 1'b1; ret_data_drv = 32'hDEAD_BEEF;
    tick();
    ret_valid_i = 1'b0;
    chk("delayed_ret_shift", {63'b0, scan_en_o}, 64'd1);
    wait_done(100);
    check_run("delay", hb, sb);
    chk("delay_ret_hs", 64'(ret_hs - rb), 64'd2);

    // Host never answers call 0: timeout after 8 WAIT_RET cycles
    hb = hs_ids.size();
    data_auto = 1'b1; ret_valid_i = 1'b0;
    do_start();
    repeat (8) tick();
    chk("wait8_no_error", {61'b0, ret_ready_o, error_o, busy_o}, 64'b101);
    tick();
    cmp_vec("timeout_error", mk(1'b0, 1'b0, 32'd0, 7'b000_0001));
    repeat (5) tick();
    cmp_vec("timeout_held", mk(1'b0, 1'b0, 32'd0, 7'b000_0001));
    chk("timeout_hs", 64'(hs_ids.size() - hb), 64'd1);

    // Restart from ERROR; return arrives in the expiry cycle and wins
    do_start();
    chk("restart_from_error", {60'b0, error_o, busy_o, call_valid_o, dut_rst_no}, 64'b0110);
    repeat (8) tick();
    ret_valid_i = 1'b1;
    tick();
    chk("expiry_handshake_wins", {60'b0, busy_o, error_o, ret_ready_o, call_valid_o}, 64'b1000);
    wait_done(100);

    // Reset during the 10th SHIFT cycle, then a clean rerun
    do_start();
    repeat (14) tick();
    chk("tenth_shift_cycle", {63'b0, scan_en_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrun_reset_outputs", {23'b0, snap()}, 64'd0);
    tick(); tick();
    chk("midrun_reset_held", {23'b0, snap()}, 64'd0);
    rst_ni = 1'b1;
    tick();
    chk("after_reset_idle", {23'b0, snap()}, 64'd0);
    hb = hs_ids.size(); sb = scan_cnt;
    do_start();
    t0 = tcount;
    wait_done(100);
    chk("rerun_latency", 64'(tcount - t0), 64'd38);
    check_run("rerun", hb, sb);

    // Restart after DONE; start pulse inside WAIT_RET is ignored
    chk("done_level_before_restart", {62'b0, done_o, dut_rst_no}, 64'b11);
    hb = hs_ids.size(); sb = scan_cnt;
    do_start();
    t0 = tcount;
    chk("restart_clears", {60'b0, done_o, dut_rst_no, busy_o, call_valid_o}, 64'b0011);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_ignored_in_wait", {61'b0, call_valid_o, busy_o, ret_ready_o}, 64'b010);
    wait_done(100);
    chk("restart_latency", 64'(tcount - t0), 64'd38);
    check_run("restart", hb, sb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpi_init_sequencer.md
Name: dpi_init_sequencer

Overview:
Reset-time DPI bridge stage that sits directly upstream of a transformed DUT.
- Holds the DUT in reset and issues each init-time DPI call (void side-effect calls and reset-value calls) to the host over a request/response mailbox.
- Serially shifts every non-void return value into the DUT scan chain, MSB first.
- Releases DUT reset only after all calls complete.

Parameters:
NUM_CALLS, 2, number of init DPI calls, issued in index order 0..NUM_CALLS-1
ARG_W, 32, argument width per call
RET_W, 32, return width per call
VOID_MASK, 2'b01, bit i=1: call i is void, return data discarded, no scan shift
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_RET before error; 0 disables the timeout
IDW, $clog2(NUM_CALLS) with a minimum of 1, call id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse to begin the sequence
call_args_i  in  NUM_CALLS*ARG_W  static arguments; slice i belongs to call i
call_valid_o  out  1  request valid
call_ready_i  in  1  host accepts the request
call_id_o  out  IDW  index of the current call
call_arg_o  out  ARG_W  argument of the current call
ret_valid_i  in  1  host return valid
ret_data_i  in  RET_W  host return value
ret_ready_o  out  1  sequencer accepts the return
scan_en_o  out  1  scan shift enable to the DUT
scan_data_o  out  1  serial scan bit
dut_rst_no  out  1  active-low reset to the DUT
busy_o  out  1  sequence in progress
done_o  out  1  sequence completed successfully (level)
error_o  out  1  timeout occurred (level)

Behaviour:
- Reset values: all outputs 0, including dut_rst_no (DUT held in reset). State = IDLE, call index = 0.
- States and transitions:
  - IDLE: wait for start_i.
  - ISSUE: call_valid_o=1, with call_id_o and call_arg_o driven from the current index.
  - WAIT_RET: ret_ready_o=1, timeout counter running.
  - SHIFT: scan_en_o=1 for exactly RET_W cycles.
  - ADVANCE, then DONE or ERROR.
- start_i:
  - Honoured in IDLE, DONE and ERROR; ignored in all other states.
  - Accepting it clears done_o/error_o, drives dut_rst_no=0, sets index=0, and enters ISSUE on the next cycle.
  - busy_o=1 in ISSUE, WAIT_RET, SHIFT and ADVANCE.
- ISSUE:
  - call_valid_o stays high and call_id_o/call_arg_o stay stable until call_ready_i.
  - Handshake is the cycle with call_valid_o & call_ready_i; the next state is WAIT_RET.
  - A ret_valid_i arriving while in ISSUE is not accepted (ret_ready_o=0).
- WAIT_RET:
  - Handshake is ret_valid_i & ret_ready_o.
  - Non-void call: latch ret_data_i into the shift register, then go to SHIFT.
  - Void call: discard the data and go to ADVANCE.
  - Timeout counter is zeroed on entry. If it reaches TIMEOUT_CYCLES without a handshake, enter ERROR.
  - A handshake in the same cycle the counter expires wins over the timeout.
- SHIFT:
  - scan_data_o = shift_q[RET_W-1]; shift_q shifts left by one each cycle.
  - RET_W cycles total, then ADVANCE.
  - scan_en_o=0 and scan_data_o=0 outside SHIFT.
- ADVANCE (1 cycle):
  - If index==NUM_CALLS-1, go to DONE.
  - Otherwise index+1, then ISSUE.
- DONE: dut_rst_no=1 on the cycle DONE is entered; done_o=1 held until the next start_i.
- ERROR: error_o=1, dut_rst_no stays 0, no further host traffic.
- Asynchronous reset mid-sequence:
  - Immediate return to IDLE with all outputs 0.
  - Any partial scan load is abandoned; the DUT stays in reset until a new start_i completes.
- Overall latency (zero-wait host): for each non-void call, ISSUE(1)+WAIT(1)+SHIFT(RET_W)+ADVANCE(1); for each void call, 3 cycles.

Test Plan:
- Default params; args = {42, 0}; host returns 0 for call 0 (void) and 32'hDEAD_BEEF for call 1, with ready and valid held high.
  -> call_id 0 then 1 observed; exactly 32 scan_en_o cycles carrying bits 1101_1110_1010_1101_1011_1110_1110_1111 MSB first; dut_rst_no rises 38 cycles after start_i; done_o=1.
- Call 1 uses arg 42; host drops call_ready_i for 5 cycles.
  -> call_valid_o, call_id_o=1 and call_arg_o=42 held stable throughout; no extra handshake occurs.
- Host delays ret_valid_i by 3 cycles, and pulses ret_valid_i once during ISSUE.
  -> the pulse during ISSUE is ignored; the later return is accepted; scan data is correct.
- TIMEOUT_CYCLES=8; host never returns for call 0.
  -> error_o=1 after 8 WAIT_RET cycles; dut_rst_no remains 0; call_valid_o stays 0.
- Assert rst_ni during the 10th SHIFT cycle, release it, then issue start_i.
  -> all outputs 0 while in reset; the full sequence reruns from call 0 with an identical scan stream.
- After DONE, pulse start_i again; also pulse start_i during WAIT_RET.
  -> the pulse in WAIT_RET is ignored; the restart drops dut_rst_no to 0 and clears done_o, then the sequence repeats identically.
